seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scheduler for a common-anode multi-digit 7-segment display.
- Shares one segment bus among DIGITS digit drivers.
- Timing comes from an internal prescaler instead of a divided clock net. The whole block runs on the single system clock.
- Adds a per-slot anti-ghosting blank interval, a per-digit enable mask and a frame-synchronous data-update handshake.

Parameters:
- DIGITS, 8: number of multiplexed digits (2..8).
- PRESCALE, 100_000: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 2_000: cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < PRESCALE.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces IDLE.
- data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- dig_mask  in  DIGITS  1 = digit displayed, 0 = digit kept dark.
- update_req  in  1  level request to load data, dp_in and dig_mask into the shadow registers.
- update_ack  out  1  one-cycle pulse; shadow loaded on this cycle.
- an  out  DIGITS  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0, state=IDLE, shadow registers=0.
  - an=all 1, seg=7'h7F, dp=1, frame_done=0, update_ack=0.
- States:
  - IDLE: entered on reset or whenever en=0. cnt and idx are held at 0; an, seg and dp are all 1.
  - BLANK: cnt < BLANK_CYCLES.
  - SHOW: BLANK_CYCLES <= cnt <= PRESCALE-1.
- Transitions:
  - IDLE→BLANK on the first cycle with en=1. That cycle has cnt=0 and idx=0.
  - cnt increments every enabled cycle. At cnt==PRESCALE-1 it wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0. When idx goes DIGITS-1→0, frame_done pulses for one cycle, aligned with the wrap cycle.
  - With en=0 mid-slot, the next cycle is IDLE. The scan restarts at digit 0 on re-enable. No partial frame_done is emitted.
- Outputs are registered, with 1-cycle latency from state/cnt/idx to pins.
  - SHOW with shadow_mask[idx]=1: an[idx]=0 and all other anodes 1. seg = hex decode of shadow nibble idx. dp = ~shadow_dp[idx].
  - SHOW with mask bit 0: the slot is still consumed, so the refresh rate stays constant, but an, seg and dp are all 1.
  - BLANK: an all 1. seg and dp are also 1.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Update handshake:
  - When scanning, the shadow is loaded only on a frame-wrap cycle with update_req=1. update_ack pulses in that same cycle.
  - In IDLE, the load happens on any cycle with update_req=1, with ack in that cycle.
  - The requester holds update_req until it sees ack, then drops it.
  - If update_req is still high on the next wrap, another load and ack occur. A level request is not an error.
  - Mid-frame changes to data never reach the pins, so there is no tearing.
- Simultaneous events:
  - en falling on a wrap cycle: the wrap is suppressed and IDLE wins. The load still happens, because IDLE also loads.
  - rst mid-frame clears everything immediately, regardless of clk.
- Widths:
  - cnt is $clog2(PRESCALE) bits.
  - idx is $clog2(DIGITS) bits, minimum 1.
  - Comparisons are unsigned.

Decomposition:
- Shared package seg7_pkg:
  - state enum {IDLE, BLANK, SHOW}.
  - 16-entry hex-to-segment constant table.
  - SEG_OFF=7'h7F.
- One sub-module, tick_gen: parameterised prescaler with en and rst. It outputs cnt and a one-cycle wrap strobe at cnt==PRESCALE-1.
- seg7_scan_ctrl holds idx, the shadow registers, the handshake and the output registers.

Test Plan (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
- Reset and scan: rst pulse, load data=16'h3A51, mask=4'hF, en=1. Expected:
  - digit 0: an=1110, seg=7'h79, from output cycle 3 to 8 of slot 0.
  - digit 1: an=1101, seg=7'h12.
  - Slot cycles 0-1 have an=1111.
  - frame_done pulses once every 32 cycles.
- Masking: mask=4'b1010, dp_in=4'b0010.
  - Slots 0 and 2 are fully dark.
  - Slot 1 shows dp=0.
  - Frame period stays 32.
- Update handshake: raise update_req with data=16'hFFFF mid-frame.
  - update_ack asserts exactly on the next wrap cycle.
  - Pins show the old nibbles until then and 7'h0E afterwards.
- en drop: en=0 at slot 2 cnt=5.
  - Next output cycle: an=1111.
  - No frame_done.
  - After re-enable, the scan starts at digit 0 with a blank interval.
- Async reset mid-SHOW: rst asserted between clock edges.
  - an, seg, dp go to all 1 and update_ack to 0 without waiting for a clk edge.
- IDLE load: en=0, update_req=1. Expected:
  - update_ack pulses in the first cycle of the request.
  - After en=1, the new data appears in frame 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared scan states, segment encodings and the hex-to-segment decode table.
// Pure constants and a lookup function; no timing or flow control involved.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side request/data bundle and the display pin bundle of the scan controller.
// The host holds update_req until it sees update_ack; the pins carry no handshake.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  en;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     dig_mask;
    logic                  update_req;
    logic                  update_ack;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output en, data, dp_in, dig_mask, update_req,
        input  update_ack, an, seg, dp, frame_done
    );

    modport slave (
        input  en, data, dp_in, dig_mask, update_req,
        output update_ack, an, seg, dp, frame_done
    );

endinterface

// File: rtl/seg7_scan_ctrl_tick_gen.sv
// Slot prescaler: counts enabled cycles 0..PRESCALE-1 and strobes wrap_o on the last one.
// Count visible in the current cycle; held at zero while en_i is low, no backpressure.
module tick_gen #(
    parameter int PRESCALE = 100_000,
    parameter int CW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with per-slot blanking, digit mask and frame-synchronous shadow load.
// Pins registered one cycle after slot state; update_ack is same-cycle, loads only on frame wrap or while idle.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 100_000,
    parameter int BLANK_CYCLES = 2_000
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_ctrl_if.slave        bus
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0]        cnt;
    logic                 slot_wrap;
    logic                 frame_wrap;
    logic                 load;
    scan_state_e          scan_state;

    logic [IW-1:0]        idx_q,      idx_d;
    logic [4*DIGITS-1:0]  sh_data_q;
    logic [DIGITS-1:0]    sh_dp_q;
    logic [DIGITS-1:0]    sh_mask_q;
    logic [DIGITS-1:0]    an_q,       an_d;
    logic [6:0]           seg_q,      seg_d;
    logic                 dp_q,       dp_d;
    logic [3:0]           nib;

    tick_gen #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.en),
        .cnt_o  (cnt),
        .wrap_o (slot_wrap)
    );

    always_comb begin
        scan_state = SHOW;
        if (!bus.en) begin
            scan_state = IDLE;
        end else if (cnt < BLANK_END) begin
            scan_state = BLANK;
        end
    end

    // slot_wrap already implies en, so a disable on the wrap cycle suppresses the frame end.
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign load       = bus.update_req && ((scan_state == IDLE) || frame_wrap);

    assign bus.update_ack = load && !rst;
    assign bus.frame_done = frame_wrap && !rst;

    always_comb begin
        idx_d = idx_q;
        if (scan_state == IDLE || frame_wrap) begin
            idx_d = '0;
        end else if (slot_wrap) begin
            idx_d = idx_q + IW'(1);
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        nib   = sh_data_q[4*int'(idx_q) +: 4];
        // A masked digit still owns its slot so the refresh rate is independent of the mask.
        if (scan_state == SHOW && sh_mask_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex2seg(nib);
            dp_d        = ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_mask_q <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            if (load) begin
                sh_data_q <= bus.data;
                sh_dp_q   <= bus.dp_in;
                sh_mask_q <= bus.dig_mask;
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a slot-arithmetic reference model queues expected pins and strobes,
// a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.DIGITS(D)) bus ();

    seg7_scan_ctrl #(
        .DIGITS       (D),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic ack;
        logic fd;
    } comb_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } pins_t;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    comb_t q_comb [$];
    pins_t q_pins [$];

    int    tests = 0;
    int    fails = 0;
    bit    chk_on = 1'b0;

    // Reference state: enabled cycles since (re)enable plus the model's shadow copy.
    int          n;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;
    logic        m_ack;

    logic        s_en;
    logic        s_req;
    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic [3:0]  s_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        bus.en         = s_en;
        bus.update_req = s_req;
        bus.data       = s_data;
        bus.dp_in      = s_dp;
        bus.dig_mask   = s_mask;
    endtask

    function automatic pins_t dark();
        pins_t p;
        p.an  = 4'hF;
        p.seg = 7'h7F;
        p.dp  = 1'b1;
        return p;
    endfunction

    // One clock cycle of the reference: strobes for this cycle, pins for the next one.
    task automatic model_cycle();
        comb_t c;
        pins_t p;
        int    cnt;
        int    dig;
        drive_bus();
        p     = dark();
        c.ack = 1'b0;
        c.fd  = 1'b0;
        if (!s_en) begin
            c.ack = s_req;
            n     = 0;
        end else begin
            cnt   = n % P;
            dig   = (n / P) % D;
            c.fd  = (cnt == P - 1) && (dig == D - 1);
            c.ack = s_req && c.fd;
            if (cnt >= B && m_mask[dig]) begin
                p.an  = ~(4'b0001 << dig);
                p.seg = hex_tab[m_data[4*dig +: 4]];
                p.dp  = ~m_dp[dig];
            end
            n++;
        end
        if (c.ack) begin
            m_data = s_data;
            m_dp   = s_dp;
            m_mask = s_mask;
        end
        m_ack = c.ack;
        q_comb.push_back(c);
        q_pins.push_back(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_cycle();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic request();
        s_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_ack) break;
        end
        s_req = 1'b0;
    endtask

    // Asserted between edges with en low and req high, so only the reset can hold ack at 0.
    task automatic do_reset();
        chk_on = 1'b0;
        s_en   = 1'b0;
        s_req  = 1'b1;
        drive_bus();
        rst = 1'b1;
        #1;
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_dp", 32'(bus.dp), 32'h1);
        chk("reset_ack", 32'(bus.update_ack), 32'h0);
        chk("reset_frame_done", 32'(bus.frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        s_req = 1'b0;
        q_comb.delete();
        q_pins.delete();
        n      = 0;
        m_data = '0;
        m_dp   = '0;
        m_mask = '0;
        q_pins.push_back(dark());
        model_cycle();
        chk_on = 1'b1;
    endtask

    always @(negedge clk) begin
        comb_t c;
        pins_t p;
        if (chk_on) begin
            if (q_comb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                c = q_comb.pop_front();
                chk("update_ack", 32'(bus.update_ack), 32'(c.ack));
                chk("frame_done", 32'(bus.frame_done), 32'(c.fd));
            end
            if (q_pins.size() >= 2) begin
                p = q_pins.pop_front();
                chk("an", 32'(bus.an), 32'(p.an));
                chk("seg", 32'(bus.seg), 32'(p.seg));
                chk("dp", 32'(bus.dp), 32'(p.dp));
            end
        end
    end

    initial begin
        s_data = '0;
        s_dp   = '0;
        s_mask = '0;
        m_ack  = 1'b0;
        do_reset();

        // Load through IDLE, then scan.
        s_data = 16'h3A51;
        s_mask = 4'hF;
        s_dp   = 4'h0;
        request();
        run(3);
        s_en = 1'b1;
        run(80);

        // Masked digits and decimal point.
        s_mask = 4'b1010;
        s_dp   = 4'b0010;
        request();
        run(70);

        // Mid-frame update: old nibbles until the wrap.
        for (int i = 0; i < 64 && (n % 32) != 11; i++) step();
        s_data = 16'hFFFF;
        s_mask = 4'hF;
        s_dp   = 4'h0;
        request();
        run(40);

        // Disable at slot 2 cnt 5, then restart from digit 0.
        for (int i = 0; i < 64 && (n % 32) != 21; i++) step();
        s_en = 1'b0;
        run(3);
        s_en = 1'b1;
        run(40);

        // Disable on the frame-wrap cycle with a pending request.
        for (int i = 0; i < 64 && (n % 32) != 31; i++) step();
        s_en   = 1'b0;
        s_data = 16'h9C07;
        s_req  = 1'b1;
        step();
        s_req = 1'b0;
        step();
        s_en = 1'b1;
        run(40);

        // Asynchronous reset while a digit is lit.
        for (int i = 0; i < 64 && (n % P) != 5; i++) step();
        do_reset();

        // Randomised traffic.
        s_data = 16'h1234;
        s_mask = 4'hF;
        request();
        s_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s_data = 16'($urandom);
            if (!s_req && $urandom_range(0, 19) == 0) begin
                s_req  = 1'b1;
                s_data = 16'($urandom);
                s_dp   = 4'($urandom);
                s_mask = 4'($urandom);
            end
            if (s_en && $urandom_range(0, 149) == 0) s_en = 1'b0;
            else if (!s_en && $urandom_range(0, 3) == 0) s_en = 1'b1;
            step();
            if (m_ack) s_req = 1'b0;
        end

        @(posedge clk);
        chk_on = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
